// File: rtl/iccm_boot_loader.sv
// ----------------------------------------------------------------------------
// iccm_boot_loader
//
// Program-load controller in front of the ICCM wrapper. It collects bytes from
// the boot UART receiver and packs them into little-endian 32-bit words. Each
// word is written through the wrapper's controller port at consecutive word
// addresses. When the end-of-program marker word arrives, ICCM ownership passes
// to the TL-UL side and the core is released from reset.
//
// Ports
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   load_en_i          sampled in IDLE: 1 = load over UART, 0 = boot as-is
//   rx_byte_i [7:0]    received byte
//   rx_valid_i         single-cycle strobe qualifying rx_byte_i
//   iccm_ctrl_addr_o   word address of the current write
//   iccm_ctrl_wdata_o  write data
//   iccm_ctrl_we_o     write strobe, one cycle per word
//   iccm_wsel_o        0 = loader owns ICCM, 1 = TL-UL owns ICCM
//   core_rst_no        active-low core reset, released in DONE
//   load_done_o        high in DONE
//   ovf_err_o          sticky: program exceeded 2**AW words
//
// Handshake: rx_valid_i is a strobe with no back-pressure. A byte counts as
// accepted in any cycle where rx_valid_i = 1 and the FSM is in LOAD or WRITE.
// It is ignored in IDLE and DONE. There is no ready signal, because the loader
// can always take a byte in LOAD/WRITE.
// ----------------------------------------------------------------------------
module iccm_boot_loader #(
    parameter int unsigned AW       = 13,
    parameter logic [31:0] EOP_WORD = 32'h0000_0FFF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_en_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    output logic [AW-1:0] iccm_ctrl_addr_o,
    output logic [31:0]   iccm_ctrl_wdata_o,
    output logic          iccm_ctrl_we_o,
    output logic          iccm_wsel_o,
    output logic          core_rst_no,
    output logic          load_done_o,
    output logic          ovf_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // state_q is the observable FSM state for checkers.
    state_e        state_q, state_d;
    logic [31:0]   asm_q, asm_d;          // byte assembly register
    logic [1:0]    cnt_q, cnt_d;          // byte lane pointer
    logic [AW-1:0] addr_cnt_q, addr_cnt_d;
    logic          wrap_q, wrap_d;        // address counter has passed 2**AW-1
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   word_full;             // assembly register with this byte merged

    always_comb begin
        word_full = asm_q;
        case (cnt_q)
            2'd0:    word_full[7:0]   = rx_byte_i;
            2'd1:    word_full[15:8]  = rx_byte_i;
            2'd2:    word_full[23:16] = rx_byte_i;
            default: word_full[31:24] = rx_byte_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        cnt_d      = cnt_q;
        addr_cnt_d = addr_cnt_q;
        wrap_d     = wrap_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: state_d = load_en_i ? LOAD : DONE;

            LOAD, WRITE: begin
                // The write strobe is issued this cycle, so the address
                // advances now. Leaving all-ones marks the address space as
                // exhausted.
                if (state_q == WRITE) begin
                    addr_cnt_d = addr_cnt_q + AW'(1);
                    if (&addr_cnt_q) wrap_d = 1'b1;
                    state_d = LOAD;
                end
                if (rx_valid_i) begin
                    asm_d = word_full;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (word_full == EOP_WORD) begin
                            state_d = DONE;
                        end else if (wrap_q) begin
                            ovf_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            wdata_d = word_full;
                            addr_d  = addr_cnt_q;
                            state_d = WRITE;
                        end
                    end
                end
            end

            default: state_d = DONE;  // DONE is terminal until reset
        endcase
    end

    // Status outputs are registered from the next state, so they line up with
    // the state they describe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            asm_q             <= '0;
            cnt_q             <= '0;
            addr_cnt_q        <= '0;
            wrap_q            <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            ovf_q             <= 1'b0;
            iccm_ctrl_we_o    <= 1'b0;
            iccm_wsel_o       <= 1'b0;
            core_rst_no       <= 1'b0;
            load_done_o       <= 1'b0;
        end else begin
            state_q           <= state_d;
            asm_q             <= asm_d;
            cnt_q             <= cnt_d;
            addr_cnt_q        <= addr_cnt_d;
            wrap_q            <= wrap_d;
            addr_q            <= addr_d;
            wdata_q           <= wdata_d;
            ovf_q             <= ovf_d;
            iccm_ctrl_we_o    <= (state_d == WRITE);
            iccm_wsel_o       <= (state_d == DONE);
            core_rst_no       <= (state_d == DONE);
            load_done_o       <= (state_d == DONE);
        end
    end

    assign iccm_ctrl_addr_o  = addr_q;
    assign iccm_ctrl_wdata_o = wdata_q;
    assign ovf_err_o         = ovf_q;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_iccm_boot_loader
//
// Directed bench for iccm_boot_loader. u_dut uses the default AW = 13, and
// u_dut_aw2 uses AW = 2 for the overflow case. Both share the stimulus inputs.
// Each DUT has its own reset, so only one of them is active at a time.
// ----------------------------------------------------------------------------
module tb_iccm_boot_loader;

    localparam logic [31:0] EOP = 32'h0000_0FFF;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        load_en;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    logic [12:0] addr;
    logic [31:0] wdata;
    logic        we, wsel, core_rst_n, done, ovf;

    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic        we2, wsel2, core_rst2_n, done2, ovf2;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboards: {addr zero-extended to 32 bits, data}
    logic [63:0] exp_q[$];
    logic [63:0] exp2_q[$];

    iccm_boot_loader u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .load_en_i        (load_en),
        .rx_byte_i        (rx_byte),
        .rx_valid_i       (rx_valid),
        .iccm_ctrl_addr_o (addr),
        .iccm_ctrl_wdata_o(wdata),
        .iccm_ctrl_we_o   (we),
        .iccm_wsel_o      (wsel),
        .core_rst_no      (core_rst_n),
        .load_done_o      (done),
        .ovf_err_o        (ovf)
    );

    iccm_boot_loader #(.AW(2)) u_dut_aw2 (
        .clk_i            (clk),
        .rst_ni           (rst2_n),
        .load_en_i        (load_en),
        .rx_byte_i        (rx_byte),
        .rx_valid_i       (rx_valid),
        .iccm_ctrl_addr_o (addr2),
        .iccm_ctrl_wdata_o(wdata2),
        .iccm_ctrl_we_o   (we2),
        .iccm_wsel_o      (wsel2),
        .core_rst_no      (core_rst2_n),
        .load_done_o      (done2),
        .ovf_err_o        (ovf2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write monitors, sampled on the falling edge.
    always @(negedge clk) begin
        logic [63:0] e;
        if (we) begin
            check("we_wsel_excl", 64'(wsel), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'(addr), wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(addr), 64'(e[63:32]));
                check("wr_data", 64'(wdata), 64'(e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (we2) begin
            check("aw2_we_wsel_excl", 64'(wsel2), 64'd0);
            if (exp2_q.size() == 0) begin
                check("aw2_unexpected_write", {32'(addr2), wdata2}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp2_q.pop_front();
                check("aw2_wr_addr", 64'(addr2), 64'(e[63:32]));
                check("aw2_wr_data", 64'(wdata2), 64'(e[31:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers return 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap > 0) idle(gap);
        end
    endtask

    // Reset u_dut; on return the DUT has left IDLE and accepts bytes.
    task automatic reset_dut(input logic le);
        load_en = le;
        rst_n   = 1'b0;
        idle(2);
        rst_n   = 1'b1;
        idle(1);
    endtask

    // ---------------- directed tests ----------------
    logic [7:0]  bytes40[40];
    logic [31:0] w;

    initial begin
        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        load_en  = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        idle(2);

        // Reset values
        check("rst_addr",  64'(addr),       64'd0);
        check("rst_wdata", 64'(wdata),      64'd0);
        check("rst_we",    64'(we),         64'd0);
        check("rst_wsel",  64'(wsel),       64'd0);
        check("rst_core",  64'(core_rst_n), 64'd0);
        check("rst_done",  64'(done),       64'd0);
        check("rst_ovf",   64'(ovf),        64'd0);

        // Skip loading: DONE one cycle after the IDLE cycle
        load_en = 1'b0;
        rst_n   = 1'b1;
        check("skip_done_idle", 64'(done), 64'd0);
        idle(1);
        check("skip_done",  64'(done),       64'd1);
        check("skip_wsel",  64'(wsel),       64'd1);
        check("skip_core",  64'(core_rst_n), 64'd1);
        check("skip_ovf",   64'(ovf),        64'd0);
        send_word(32'h1234_5678, 0);   // ignored in DONE; the monitor flags any write
        idle(2);
        check("skip_still_done", 64'(done), 64'd1);

        // Basic load with gaps
        reset_dut(1'b1);
        exp_q.push_back({32'd0, 32'h0000_0013});
        exp_q.push_back({32'd1, 32'h0010_0093});
        send_word(32'h0000_0013, 2);
        send_word(32'h0010_0093, 1);
        send_byte(8'hFF); idle(1);
        send_byte(8'h0F); idle(3);
        send_byte(8'h00); idle(1);
        check("basic_done_pre", 64'(done), 64'd0);
        check("basic_core_pre", 64'(core_rst_n), 64'd0);
        send_byte(8'h00);
        check("basic_done",  64'(done),       64'd1);
        check("basic_wsel",  64'(wsel),       64'd1);
        check("basic_core",  64'(core_rst_n), 64'd1);
        check("basic_we",    64'(we),         64'd0);
        check("basic_hold_addr",  64'(addr),  64'd1);
        check("basic_hold_wdata", 64'(wdata), 64'h0010_0093);
        send_word(32'hDEAD_BEEF, 0);   // ignored in DONE
        idle(2);
        check("basic_q_empty", 64'(exp_q.size()), 64'd0);

        // 40 bytes back-to-back, then EOP
        reset_dut(1'b1);
        for (int i = 0; i < 40; i++) bytes40[i] = 8'(i * 37 + 5);
        for (int k = 0; k < 10; k++) begin
            w = {bytes40[4*k+3], bytes40[4*k+2], bytes40[4*k+1], bytes40[4*k]};
            exp_q.push_back({32'(k), w});
        end
        for (int i = 0; i < 40; i++) send_byte(bytes40[i]);
        send_word(EOP, 0);
        check("burst_done", 64'(done), 64'd1);
        idle(2);
        check("burst_q_empty", 64'(exp_q.size()), 64'd0);
        check("burst_last_addr", 64'(addr), 64'd9);

        // Asynchronous reset mid-load discards partial word and address
        reset_dut(1'b1);
        exp_q.push_back({32'd0, 32'h0BAD_0001});
        exp_q.push_back({32'd1, 32'h0BAD_0002});
        send_word(32'h0BAD_0001, 0);
        send_word(32'h0BAD_0002, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("mid_addr_pre", 64'(addr), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr",  64'(addr),       64'd0);
        check("mid_rst_wdata", 64'(wdata),      64'd0);
        check("mid_rst_core",  64'(core_rst_n), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        exp_q.push_back({32'd0, 32'hDDCC_BBAA});
        send_word(32'hDDCC_BBAA, 1);
        send_word(EOP, 1);
        check("mid_done", 64'(done), 64'd1);
        idle(2);
        check("mid_q_empty", 64'(exp_q.size()), 64'd0);

        // EOP whose first byte lands in the WRITE cycle of the previous word
        reset_dut(1'b1);
        exp_q.push_back({32'd0, 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D, 0);
        send_byte(8'hFF);              // arrives during WRITE
        idle(2);
        send_byte(8'h0F);
        idle(1);
        send_byte(8'h00);
        send_byte(8'h00);
        check("split_done", 64'(done), 64'd1);
        check("split_we",   64'(we),   64'd0);
        idle(2);
        check("split_q_empty", 64'(exp_q.size()), 64'd0);

        // AW = 2: the fifth word overflows
        rst_n   = 1'b0;
        load_en = 1'b1;
        idle(1);
        rst2_n  = 1'b1;
        idle(1);
        for (int k = 0; k < 4; k++) exp2_q.push_back({32'(k), 32'h1111_1111 * 32'(k + 1)});
        for (int k = 0; k < 4; k++) send_word(32'h1111_1111 * 32'(k + 1), 0);
        idle(1);
        check("aw2_ovf_pre",  64'(ovf2),  64'd0);
        check("aw2_done_pre", 64'(done2), 64'd0);
        send_word(32'h5555_5555, 0);
        check("aw2_ovf",  64'(ovf2),        64'd1);
        check("aw2_done", 64'(done2),       64'd1);
        check("aw2_core", 64'(core_rst2_n), 64'd1);
        send_word(EOP, 0);
        idle(2);
        check("aw2_q_empty", 64'(exp2_q.size()), 64'd0);
        check("aw2_last_addr", 64'(addr2), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
